// File: rtl/gate_input_pkg.sv
// gate_input_pkg
//   Shared types and default constants for the gate-input debouncer.
//   Contents:
//     deb_state_e        per-channel debounce state (ST_STABLE / ST_CHECK)
//     DEF_SYNC_STAGES    default synchroniser depth
//     DEF_STABLE_CYCLES  default number of consecutive synced cycles to accept a level
package gate_input_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } deb_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One input bit: synchroniser chain, STABLE/CHECK debounce FSM with a
//   consecutive-cycle counter, and registered one-cycle edge pulses.
//   Ports:
//     clk      in   system clock (rising edge)
//     rst_n    in   synchronous reset, active low
//     raw_i    in   raw asynchronous level
//     clean_o  out  debounced level
//     rise_o   out  one-cycle pulse in the first cycle clean_o is 1 after being 0
//     fall_o   out  one-cycle pulse in the first cycle clean_o is 0 after being 1
//     busy_o   out  high while a candidate level is being counted
module debounce_channel
    import gate_input_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int                 CNT_W    = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    deb_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q,  rise_d;
    logic                   fall_q,  fall_d;

    // Bit 0 samples the asynchronous input; the top bit is the first value
    // safe to use in clocked logic.
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // update together from pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt counts how many consecutive synced cycles have differed from the
    // clean level, including the current one.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; without
        // them a missed branch would hold its value and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            ST_STABLE: begin
                if (sync != clean_q) begin
                    state_d = ST_CHECK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                if (sync == clean_q) begin
                    // Candidate level collapsed before qualifying: glitch.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // This cycle completes STABLE_CYCLES consecutive mismatches.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    clean_d = sync;
                    rise_d  = sync;
                    fall_d  = ~sync;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign busy_o  = (state_q == ST_CHECK);

endmodule

// File: rtl/gate_input_debouncer.sv
// gate_input_debouncer
//   Input stage for the two-input logic gates: synchronises and debounces
//   N_CH raw switch/button levels. clean_out[0] drives gate operand a,
//   clean_out[1] drives operand b. Channels are fully independent.
//   Ports:
//     clk         in   system clock (rising edge)
//     rst_n       in   synchronous reset, active low
//     raw_in      in   [N_CH] raw asynchronous levels
//     clean_out   out  [N_CH] debounced levels
//     rise_pulse  out  [N_CH] one-cycle pulse on clean 0->1
//     fall_pulse  out  [N_CH] one-cycle pulse on clean 1->0
//     busy        out  [N_CH] channel is qualifying a new level
module gate_input_debouncer
    import gate_input_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] busy
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw_in[i]),
            .clean_o (clean_out[i]),
            .rise_o  (rise_pulse[i]),
            .fall_o  (fall_pulse[i]),
            .busy_o  (busy[i])
        );
    end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// tb_gate_input_debouncer
//   Directed stimulus for the debouncer. A reference model describes each
//   channel as "the synced value is the raw value from SYNC_STAGES edges ago;
//   a level is adopted once the last STABLE_CYCLES synced samples all equal it"
//   and is compared against the DUT every cycle. Directed scenarios add
//   literal expectations at specific edges.
module tb_gate_input_debouncer;

    localparam int N  = 2;
    localparam int S  = 2;
    localparam int K  = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_in = 2'b11;
    logic [N-1:0] clean_out, rise_pulse, fall_pulse, busy;

    int n_vec = 0;
    int n_err = 0;

    gate_input_debouncer #(
        .N_CH          (N),
        .SYNC_STAGES   (S),
        .STABLE_CYCLES (K)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_pipe [N][S];
    logic         m_win  [N][K];
    logic [N-1:0] m_clean, m_rise, m_fall, m_busy;
    bit           model_on = 1'b0;

    initial begin : model
        logic s;
        bit   all_eq;
        forever begin
            @(posedge clk);
            for (int c = 0; c < N; c++) begin
                if (!rst_n) begin
                    for (int j = 0; j < S; j++) m_pipe[c][j] = 1'b0;
                    for (int j = 0; j < K; j++) m_win[c][j]  = 1'b0;
                    m_clean[c] = 1'b0;
                    m_rise[c]  = 1'b0;
                    m_fall[c]  = 1'b0;
                    m_busy[c]  = 1'b0;
                end else begin
                    s = m_pipe[c][S-1];
                    for (int j = S-1; j > 0; j--) m_pipe[c][j] = m_pipe[c][j-1];
                    m_pipe[c][0] = raw_in[c];
                    for (int j = K-1; j > 0; j--) m_win[c][j] = m_win[c][j-1];
                    m_win[c][0] = s;
                    all_eq = 1'b1;
                    for (int j = 0; j < K; j++) if (m_win[c][j] !== s) all_eq = 1'b0;
                    m_rise[c] = 1'b0;
                    m_fall[c] = 1'b0;
                    if (all_eq && s != m_clean[c]) begin
                        m_clean[c] = s;
                        m_rise[c]  = s;
                        m_fall[c]  = ~s;
                    end
                    m_busy[c] = (s != m_clean[c]);
                end
            end
            model_on = 1'b1;
        end
    end

    // ---------------- per-cycle compare + pulse counters ----------------
    int rise_cnt [N];
    int fall_cnt [N];

    initial begin : compare
        for (int c = 0; c < N; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            if (model_on) begin
                check("model_clean", 32'(clean_out),  32'(m_clean));
                check("model_rise",  32'(rise_pulse), 32'(m_rise));
                check("model_fall",  32'(fall_pulse), 32'(m_fall));
                check("model_busy",  32'(busy),       32'(m_busy));
            end
            for (int c = 0; c < N; c++) begin
                if (rise_pulse[c] === 1'b1) rise_cnt[c]++;
                if (fall_pulse[c] === 1'b1) fall_cnt[c]++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [N-1:0] v);
        @(negedge clk);
        raw_in = v;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    int base;

    initial begin : stim
        // 1: reset held with raw high, then release.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_clean", 32'(clean_out),  32'(2'b00));
            check("rst_rise",  32'(rise_pulse), 32'(2'b00));
            check("rst_fall",  32'(fall_pulse), 32'(2'b00));
            check("rst_busy",  32'(busy),       32'(2'b00));
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle(5);
        check("t1_e5_clean", 32'(clean_out), 32'(2'b00));
        check("t1_e5_busy",  32'(busy),      32'(2'b11));
        tick();
        check("t1_e6_clean", 32'(clean_out),  32'(2'b11));
        check("t1_e6_rise",  32'(rise_pulse), 32'(2'b11));
        check("t1_e6_busy",  32'(busy),       32'(2'b00));
        tick();
        check("t1_e7_rise",  32'(rise_pulse), 32'(2'b00));

        // 2: clean step on channel 0 from an all-low baseline.
        set_raw(2'b00);
        settle(10);
        set_raw(2'b01);
        settle(2);
        check("t2_e2_busy",  32'(busy),       32'(2'b00));
        tick();
        check("t2_e3_busy",  32'(busy),       32'(2'b01));
        settle(2);
        check("t2_e5_busy",  32'(busy),       32'(2'b01));
        check("t2_e5_clean", 32'(clean_out),  32'(2'b00));
        tick();
        check("t2_e6_clean", 32'(clean_out),  32'(2'b01));
        check("t2_e6_rise",  32'(rise_pulse), 32'(2'b01));
        check("t2_e6_busy",  32'(busy),       32'(2'b00));
        tick();
        check("t2_e7_rise",  32'(rise_pulse), 32'(2'b00));

        // 3: 3-cycle glitch on channel 1 is rejected, 4-cycle level is accepted.
        base = rise_cnt[1];
        set_raw(2'b11);
        settle(3);
        set_raw(2'b01);
        settle(2);
        check("t3_e5_busy",  32'(busy),       32'(2'b10));
        tick();
        check("t3_e6_busy",  32'(busy),       32'(2'b00));
        check("t3_e6_clean", 32'(clean_out),  32'(2'b01));
        check("t3_e6_rise",  32'(rise_pulse), 32'(2'b00));
        settle(4);
        check("t3_glitch_rises", 32'(rise_cnt[1] - base), 32'(0));
        set_raw(2'b11);
        settle(4);
        set_raw(2'b01);
        settle(2);
        check("t3_acc_clean", 32'(clean_out),  32'(2'b11));
        check("t3_acc_rise",  32'(rise_pulse), 32'(2'b10));
        settle(10);
        check("t3_back_low",  32'(clean_out),  32'(2'b01));

        // 4: bounce on channel 0 then held high: exactly one rise.
        set_raw(2'b00);
        settle(10);
        base = rise_cnt[0];
        set_raw(2'b01); tick();
        set_raw(2'b00); tick();
        set_raw(2'b01); tick();
        set_raw(2'b00); tick();
        set_raw(2'b01);
        settle(4);
        check("t4_e8_clean",  32'(clean_out),  32'(2'b00));
        tick();
        check("t4_e9_clean",  32'(clean_out),  32'(2'b00));
        tick();
        check("t4_e10_clean", 32'(clean_out),  32'(2'b01));
        check("t4_e10_rise",  32'(rise_pulse), 32'(2'b01));
        settle(4);
        check("t4_rise_count", 32'(rise_cnt[0] - base), 32'(1));

        // 5: both high, drop channel 1 only.
        set_raw(2'b11);
        settle(10);
        check("t5_both_high", 32'(clean_out), 32'(2'b11));
        base = fall_cnt[1];
        set_raw(2'b01);
        settle(5);
        check("t5_e5_clean", 32'(clean_out),  32'(2'b11));
        check("t5_e5_fall",  32'(fall_pulse), 32'(2'b00));
        tick();
        check("t5_e6_fall",  32'(fall_pulse), 32'(2'b10));
        check("t5_e6_clean", 32'(clean_out),  32'(2'b01));
        check("t5_e6_rise",  32'(rise_pulse), 32'(2'b00));
        check("t5_e6_busy",  32'(busy),       32'(2'b00));
        tick();
        check("t5_e7_fall",  32'(fall_pulse), 32'(2'b00));
        check("t5_fall_count", 32'(fall_cnt[1] - base), 32'(1));

        // 6: reset in the middle of a CHECK on channel 0.
        set_raw(2'b00);
        settle(10);
        set_raw(2'b01);
        settle(3);
        check("t6_e3_busy", 32'(busy), 32'(2'b01));
        @(negedge clk);
        rst_n = 1'b0;
        tick();
        check("t6_rst_clean", 32'(clean_out),  32'(2'b00));
        check("t6_rst_busy",  32'(busy),       32'(2'b00));
        check("t6_rst_rise",  32'(rise_pulse), 32'(2'b00));
        check("t6_rst_fall",  32'(fall_pulse), 32'(2'b00));
        @(negedge clk);
        rst_n = 1'b1;
        settle(5);
        check("t6_e5_clean", 32'(clean_out),  32'(2'b00));
        check("t6_e5_busy",  32'(busy),       32'(2'b01));
        tick();
        check("t6_e6_clean", 32'(clean_out),  32'(2'b01));
        check("t6_e6_rise",  32'(rise_pulse), 32'(2'b01));
        settle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
